// File: rtl/conv_relu_maxpool.sv
// conv_relu_maxpool
//   Streaming post-processing stage behind the convolver datapath. It keeps only
//   the conv results whose KERNEL_SIZE x KERNEL_SIZE window lies fully inside the
//   image, applies ReLU, and then 2x2/stride-2 max-pools the result.
//
//   Ports
//     clk        : single clock, rising edge
//     reset      : synchronous, active-low
//     write      : pixel write strobe, the same strobe the datapath sees
//     conv_in    : datapath add_result, signed, PIPE_LATENCY cycles behind write
//     pool_out   : pooled ReLU value, signed and always >= 0
//     pool_valid : one-cycle pulse; pool_out is valid in this cycle
//     frame_done : one-cycle pulse that comes with the last pooled value of a frame
module conv_relu_maxpool #(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BIT     = 8,
  parameter int KERNEL_SIZE  = 5,
  parameter int IMAGE_SIZE   = 28,
  parameter int PIPE_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write,
  input  logic signed [DATA_WIDTH-1:0] conv_in,
  output logic signed [DATA_WIDTH-1:0] pool_out,
  output logic                         pool_valid,
  output logic                         frame_done
);

  localparam int CONV_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int POOL_SIZE = CONV_SIZE / 2;
  localparam int CW        = $clog2(IMAGE_SIZE);
  localparam int PW        = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;

  localparam logic [CW-1:0] KM1   = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] IMAX  = CW'(IMAGE_SIZE - 1);
  // Only the even-sized part of the conv map is pooled. When CONV_SIZE is odd,
  // the last row and column fall outside this range.
  localparam logic [CW-1:0] CEVEN = CW'(2 * POOL_SIZE);
  localparam logic [CW-1:0] CLAST = CW'(2 * POOL_SIZE - 1);
  // Zero in Q(DATA_WIDTH-FRAC_BIT).FRAC_BIT. ReLU and max do not depend on the format.
  localparam logic signed [DATA_WIDTH-1:0] ZERO = DATA_WIDTH'(0) << FRAC_BIT;

  localparam logic [0:0] EVEN_COL = 1'b0;
  localparam logic [0:0] ODD_COL  = 1'b1;

  // Write strobe delayed to line up with conv_in. Gaps in write pass through unchanged.
  logic [PIPE_LATENCY-1:0] vld_pipe;
  logic                    w_d;

  logic [CW-1:0] row, col;
  logic signed [DATA_WIDTH-1:0] pair;
  logic signed [DATA_WIDTH-1:0] linebuf [POOL_SIZE];

  logic                         in_win, in_pool, last_pos;
  logic [CW-1:0]                cr, cc;
  logic [PW-1:0]                lb_idx;
  logic [0:0]                   col_state;
  logic signed [DATA_WIDTH-1:0] relu, pmax, lb_rd, qmax;

  assign w_d = vld_pipe[PIPE_LATENCY-1];

  always_comb begin
    in_win    = (row >= KM1) && (col >= KM1);
    cr        = row - KM1;
    cc        = col - KM1;
    in_pool   = in_win && (cr < CEVEN) && (cc < CEVEN);
    last_pos  = (cr == CLAST) && (cc == CLAST);
    col_state = cc[0] ? ODD_COL : EVEN_COL;
    lb_idx    = PW'(cc >> 1);
    relu      = (conv_in < ZERO) ? ZERO : conv_in;
    // Horizontal max of the two columns in the current row pair.
    pmax      = (relu > pair) ? relu : pair;
    lb_rd     = linebuf[lb_idx];
    // Vertical max against the horizontal max stored from the even row.
    qmax      = (lb_rd > pmax) ? lb_rd : pmax;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe   <= '0;
      row        <= '0;
      col        <= '0;
      pair       <= '0;
      pool_out   <= '0;
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vld_pipe   <= PIPE_LATENCY'({vld_pipe, write});
      pool_valid <= 1'b0;
      frame_done <= 1'b0;
      if (w_d) begin
        if (col == IMAX) begin
          col <= '0;
          row <= (row == IMAX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (in_pool) begin
          if (col_state == EVEN_COL) begin
            pair <= relu;
          end else if (cr[0]) begin
            pool_out   <= qmax;
            pool_valid <= 1'b1;
            frame_done <= last_pos;
          end
        end
      end
    end
  end

  // Every entry is written on an even conv row before it is read on the
  // following odd row, so the buffer has no reset.
  always_ff @(posedge clk) begin
    if (reset && w_d && in_pool && (col_state == ODD_COL) && !cr[0])
      linebuf[lb_idx] <= pmax;
  end

endmodule

// File: tb/tb_conv_relu_maxpool.sv
// Bench for conv_relu_maxpool.
//   The driver presents each pixel's conv value two cycles after its write.
//   When no result is due, conv_in carries random filler.
//   A frame-level model works out every pooled value directly from the image.
//   The compare process checks each pool_valid pulse against that model.
module tb_conv_relu_maxpool;
  localparam int IMG  = 28;
  localparam int K    = 5;
  localparam int NPIX = IMG * IMG;
  localparam int NP   = 12;

  logic               clk = 1'b0;
  logic               reset, write;
  logic signed [15:0] conv_in;
  logic signed [15:0] pool_out;
  logic               pool_valid, frame_done;

  conv_relu_maxpool #(
    .DATA_WIDTH(16), .FRAC_BIT(8), .KERNEL_SIZE(K), .IMAGE_SIZE(IMG), .PIPE_LATENCY(2)
  ) dut (
    .clk(clk), .reset(reset), .write(write), .conv_in(conv_in),
    .pool_out(pool_out), .pool_valid(pool_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] val;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_cur;
  int          n_cmp = 0, n_bad = 0, cyc = 0, fd_cnt = 0, pv_cnt = 0;
  int          watch_cyc = 0, n_ab = 0;
  bit          watch = 0, gap_mode = 0, prev_pv = 0;
  bit          slot_v[2];
  logic [15:0] slot_d[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Conv value for image pixel (r,c) in each test.
  function automatic logic [15:0] pixval(input int tid, input int fr, input int r, input int c);
    int cr, cc;
    cr = r - (K - 1);
    cc = c - (K - 1);
    case (tid)
      1: return 16'h3840;
      2: return 16'hFF00;
      3: begin
        if (cr == 2 && cc == 3)      return 16'h0500;
        else if (cr == 3 && cc == 2) return 16'hFA00;
        else                         return 16'h0100;
      end
      4: return 16'h0200;
      5: return 16'(((r * 37 + c * 11 + fr * 5) % 200 - 60) * 16);
      default: return (fr == 0) ? 16'h0100 : 16'h0300;
    endcase
  endfunction

  // Pool (pr,pc) = max(0, the four conv values it covers).
  // Its result comes from image pixel (2pr+K, 2pc+K). Only pools whose
  // pixel index is <= limit are expected.
  task automatic push_frame(input int tid, input int fr, input int limit);
    for (int pr = 0; pr < NP; pr++) begin
      for (int pc = 0; pc < NP; pc++) begin
        logic signed [15:0] best, v;
        int pe;
        best = 16'sd0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            v = pixval(tid, fr, 2 * pr + dr + K - 1, 2 * pc + dc + K - 1);
            if (v > best) best = v;
          end
        pe = (2 * pr + K) * IMG + 2 * pc + K;
        if (pe <= limit) exp_q.push_back('{best, (pr == NP - 1) && (pc == NP - 1)});
      end
    end
  endtask

  task automatic step(input bit w, input logic [15:0] v, input bit rst);
    @(posedge clk);
    #1;
    reset   = !rst;
    write   = w;
    conv_in = slot_v[1] ? slot_d[1] : 16'($urandom);
    if (rst) begin
      slot_v[0] = 1'b0;
      slot_v[1] = 1'b0;
    end else begin
      slot_v[1] = slot_v[0];
      slot_d[1] = slot_d[0];
      slot_v[0] = w;
      slot_d[0] = v;
    end
  endtask

  task automatic run_frame(input int tid, input int fr, input bit gaps, input bit wfirst);
    for (int i = 0; i < NPIX; i++) begin
      step(1'b1, pixval(tid, fr, i / IMG, i % IMG), 1'b0);
      if (wfirst && i == 0) begin
        watch_cyc = cyc + 148;
        watch     = 1'b1;
      end
      if (gaps) step(1'b0, 16'h0, 1'b0);
    end
  endtask

  task automatic begin_test();
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    fd_cnt = 0;
    pv_cnt = 0;
  endtask

  task automatic end_test(input int exp_fd, input int exp_pv);
    repeat (8) step(1'b0, 16'h0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    chk("frame_done_count", fd_cnt, exp_fd);
    chk("pulse_count", pv_cnt, exp_pv);
    chk("first_pulse_seen", watch, 0);
    watch = 1'b0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (pool_valid) begin
      pv_cnt++;
      if (watch) begin
        chk("first_pulse_cycle", cyc, watch_cyc);
        watch = 1'b0;
      end
      if (gap_mode) chk("pulse_spacing", prev_pv, 0);
      chk("pulse_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e_cur = exp_q.pop_front();
        chk("pool_out", $unsigned(pool_out), e_cur.val);
        chk("frame_done", frame_done, e_cur.last);
      end
      if (frame_done) fd_cnt++;
    end else if (reset) begin
      chk("frame_done_idle", frame_done, 0);
    end
    prev_pv = pool_valid;
  end

  initial begin
    reset = 1'b0; write = 1'b0; conv_in = '0;
    slot_v[0] = 1'b0; slot_v[1] = 1'b0; slot_d[0] = '0; slot_d[1] = '0;
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b0);
    @(negedge clk);
    chk("reset_pool_valid", pool_valid, 0);
    chk("reset_pool_out", $unsigned(pool_out), 0);
    chk("reset_frame_done", frame_done, 0);

    // Constant frame
    begin_test();
    push_frame(1, 0, NPIX);
    chk("model_const", exp_q[0].val, 16'h3840);
    run_frame(1, 0, 1'b0, 1'b1);
    end_test(1, 144);

    // Negative input clamps to zero
    begin_test();
    push_frame(2, 0, NPIX);
    chk("model_neg", exp_q[5].val, 16'h0000);
    run_frame(2, 0, 1'b0, 1'b0);
    end_test(1, 144);

    // Max selection
    begin_test();
    push_frame(3, 0, NPIX);
    chk("model_pin13", exp_q[13].val, 16'h0500);
    chk("model_pin12", exp_q[12].val, 16'h0100);
    chk("model_last", exp_q[143].last, 1);
    chk("model_size", exp_q.size(), 144);
    run_frame(3, 0, 1'b0, 1'b0);
    end_test(1, 144);

    // Write gaps
    begin_test();
    push_frame(4, 0, NPIX);
    gap_mode = 1'b1;
    run_frame(4, 0, 1'b1, 1'b0);
    end_test(1, 144);
    gap_mode = 1'b0;

    // Reset mid-frame after 400 writes. Pixels 398 and 399 are still in the
    // pipe at the reset edge and are lost.
    begin_test();
    push_frame(5, 0, 397);
    n_ab = exp_q.size();
    chk("model_abort_count", n_ab, 60);
    for (int i = 0; i < 400; i++) step(1'b1, pixval(5, 0, i / IMG, i % IMG), 1'b0);
    step(1'b0, 16'h0, 1'b1);
    push_frame(5, 1, NPIX);
    run_frame(5, 1, 1'b0, 1'b1);
    end_test(1, n_ab + 144);

    // Back-to-back frames
    begin_test();
    push_frame(6, 0, NPIX);
    push_frame(6, 1, NPIX);
    chk("model_b2b", exp_q[144].val, 16'h0300);
    run_frame(6, 0, 1'b0, 1'b0);
    run_frame(6, 1, 1'b0, 1'b0);
    end_test(2, 288);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
